cc_mux3_arbiter: RTL and testbench
==================================

CC_MUX3_ARBITER -- requirements
Module: cc_mux3_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, is the maximum consecutive grant cycles one owner keeps while another requester waits; the legal range is 2..256.
REQ-002 Parameter DATAWIDTH_BUS, default 8, is carried only for instantiation symmetry with the shared mux; it is unused internally.
REQ-003 CC_MUX3_ARBITER_CLOCK_50  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 CC_MUX3_ARBITER_RESET_InLow  in  1  reset, synchronous, active-low.
REQ-005 CC_MUX3_ARBITER_Request_In  in  3  per-requester bus request; bit i is requester i.
REQ-006 CC_MUX3_ARBITER_Grant_Out  out  3  one-hot registered grant; it is 000 when there is no owner.
REQ-007 CC_MUX3_ARBITER_Selector_Out  out  2  registered mux selector: 2'b00 for requester 0, 2'b01 for 1, 2'b10 for 2; 2'b11 is never driven.
REQ-008 CC_MUX3_ARBITER_Valid_Out  out  1  high exactly when Grant_Out is nonzero.

Function
REQ-009 The FSM SHALL have two states: IDLE (no owner) and OWNED (one owner).
REQ-010 In IDLE with any Request_In bit set, at the next edge the block SHALL enter OWNED and grant the winner, so grant latency is 1 cycle.
REQ-011 The winner SHALL be the first requesting index in round-robin order starting at (last_owner+1) mod 3.
REQ-012 In IDLE with Request_In=000, all outputs SHALL hold; Selector_Out keeps its last value.
REQ-013 In OWNED, while the owner's request is high and hold_cnt < MAX_HOLD-1, the grant SHALL persist and hold_cnt SHALL increment.
REQ-014 When the owner drops its request and others are requesting, the grant SHALL move directly to the round-robin winner at that edge, with no idle bubble.
REQ-015 When the owner drops its request and no one else is requesting, the block SHALL go to IDLE at that edge; Grant_Out becomes 000 and Valid_Out 0.
REQ-016 When hold_cnt = MAX_HOLD-1 and another requester is waiting, the grant SHALL be forcibly moved to the round-robin winner.
REQ-017 When hold_cnt = MAX_HOLD-1 and no other requester is waiting, the owner SHALL keep the grant and hold_cnt SHALL reset to 0.
REQ-018 hold_cnt SHALL be cleared to 0 on every new grant.
REQ-019 hold_cnt width SHALL be clog2(MAX_HOLD) bits and it SHALL never wrap past MAX_HOLD-1.
REQ-020 last_owner SHALL update on every grant, including forced switches.
REQ-021 Grant_Out, Selector_Out and Valid_Out SHALL always be mutually consistent within the same cycle.
REQ-022 Simultaneous requests SHALL be resolved only by the round-robin pointer and never by fixed index priority.

Reset
REQ-023 While RESET_InLow is 0 at an edge: state=IDLE, Grant_Out=000, Selector_Out=2'b00, Valid_Out=0, hold_cnt=0, last_owner=2 (so requester 0 wins first).
REQ-024 Reset asserted mid-grant SHALL drop the grant at that same edge; requests present during reset SHALL be ignored.
REQ-025 The first arbitration SHALL occur at the first edge after RESET_InLow returns to 1.

Structure
REQ-026 A shared package SHALL hold the state encodings (IDLE, OWNED), the selector codes SEL_REQ0/1/2 = 2'b00/01/10, and the requester count constant 3.
REQ-027 There SHALL be one combinational sub-module, cc_rr_pick3: inputs are the request vector and last_owner; outputs are the winner index and an any-request flag.
REQ-028 All outputs SHALL be driven from registers; no combinational path SHALL exist from Request_In to any output.

Verification
REQ-029 Reset scenario: after reset, Request_In=111 -> one cycle later Grant_Out=001, Selector_Out=00, Valid_Out=1.
REQ-030 Round-robin scenario: hold Request_In=111 with MAX_HOLD=4 -> the grant rotates 001->010->100->001, each owner held exactly 4 cycles.
REQ-031 Early release scenario: owner 0 granted with Request_In=011, then bit 0 drops -> at the next edge Grant_Out=010, Selector_Out=01, with no bubble.
REQ-032 Sole-requester scenario: Request_In=100 held for 40 cycles with MAX_HOLD=16 -> Grant_Out stays 100 and Selector_Out stays 10 throughout.
REQ-033 Release-to-idle scenario: owner 2 drops with no other requests -> Grant_Out=000 and Valid_Out=0 at the next edge, and Selector_Out holds 10.
REQ-034 Mid-grant reset scenario: assert RESET_InLow=0 for 1 cycle during OWNED -> outputs match the reset values of REQ-023, and the next grant with Request_In=111 goes to requester 0.

Source files
------------

// File: rtl/cc_mux3_arbiter_pkg.sv
// Shared definitions for the three-requester round-robin bus arbiter:
// FSM encodings, selector codes and the selector-to-grant decode.
package cc_mux3_arbiter_pkg;

    localparam int unsigned NUM_REQ = 32'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;

    // 2'b11 is not a legal selector and decodes to no grant at all.
    function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [1:0] sel);
        logic [NUM_REQ-1:0] oh;
        case (sel)
            SEL_REQ0: oh = 3'b001;
            SEL_REQ1: oh = 3'b010;
            SEL_REQ2: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/cc_rr_pick3.sv
// Combinational round-robin picker: first requester at or after
// (last_owner+1) mod 3, plus a flag that anyone is requesting.
module cc_rr_pick3
    import cc_mux3_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_last_owner,
    output logic [1:0]         o_winner,
    output logic               o_any_req
);

    // Search order rotates so the previous owner is always checked last.
    always_comb begin
        o_winner  = SEL_REQ0;
        o_any_req = |i_req;
        case (i_last_owner)
            SEL_REQ0: begin
                if (i_req[1])      o_winner = SEL_REQ1;
                else if (i_req[2]) o_winner = SEL_REQ2;
                else               o_winner = SEL_REQ0;
            end
            SEL_REQ1: begin
                if (i_req[2])      o_winner = SEL_REQ2;
                else if (i_req[0]) o_winner = SEL_REQ0;
                else               o_winner = SEL_REQ1;
            end
            default: begin
                if (i_req[0])      o_winner = SEL_REQ0;
                else if (i_req[1]) o_winner = SEL_REQ1;
                else               o_winner = SEL_REQ2;
            end
        endcase
    end

endmodule

// File: rtl/cc_mux3_arbiter.sv
// Three-requester round-robin arbiter with a bounded hold time, producing
// registered one-hot grant, mux selector and valid for a shared bus mux.
module cc_mux3_arbiter
    import cc_mux3_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD      = 32'd16,
    parameter int unsigned DATAWIDTH_BUS = 32'd8
)(
    input  logic               CC_MUX3_ARBITER_CLOCK_50,
    input  logic               CC_MUX3_ARBITER_RESET_InLow,
    input  logic [NUM_REQ-1:0] CC_MUX3_ARBITER_Request_In,
    output logic [NUM_REQ-1:0] CC_MUX3_ARBITER_Grant_Out,
    output logic [1:0]         CC_MUX3_ARBITER_Selector_Out,
    output logic               CC_MUX3_ARBITER_Valid_Out
);

    localparam int unsigned       HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 32'd1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);

    if ((MAX_HOLD < 32'd2) || (MAX_HOLD > 32'd256)) begin : g_bad_max_hold
        $error("cc_mux3_arbiter: MAX_HOLD must be within 2..256");
    end
    if (DATAWIDTH_BUS < 32'd1) begin : g_bad_datawidth
        $error("cc_mux3_arbiter: DATAWIDTH_BUS must be at least 1");
    end

    arb_state_e         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [1:0]         r_sel;
    logic               r_valid;
    logic [HOLD_W-1:0]  r_hold;
    logic [1:0]         r_last;

    arb_state_e         w_state_nxt;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [1:0]         w_sel_nxt;
    logic               w_valid_nxt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic [1:0]         w_last_nxt;

    logic [1:0]         w_winner;
    logic               w_any_req;
    logic               w_owner_req;
    logic               w_others_req;
    logic               w_take_new;

    cc_rr_pick3 u_pick (
        .i_req        (CC_MUX3_ARBITER_Request_In),
        .i_last_owner (r_last),
        .o_winner     (w_winner),
        .o_any_req    (w_any_req)
    );

    // In OWNED the current grant marks the owner, so masking with it splits
    // the owner's request from everyone else's.
    assign w_owner_req  = |(CC_MUX3_ARBITER_Request_In & r_grant);
    assign w_others_req = |(CC_MUX3_ARBITER_Request_In & ~r_grant);

    // Decide whether this edge hands the bus to the round-robin winner.
    always_comb begin
        w_take_new = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_take_new = w_any_req;
            end
            ST_OWNED: begin
                if (w_owner_req) begin
                    w_take_new = (r_hold == HOLD_LAST) && w_others_req;
                end else begin
                    w_take_new = w_any_req;
                end
            end
            default: begin
                w_take_new = 1'b0;
            end
        endcase
    end

    // Next-state and next-output computation; everything holds by default.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_hold_nxt  = r_hold;
        w_last_nxt  = r_last;
        if (w_take_new) begin
            w_state_nxt = ST_OWNED;
            w_grant_nxt = sel_to_onehot(w_winner);
            w_sel_nxt   = w_winner;
            w_valid_nxt = 1'b1;
            w_hold_nxt  = '0;
            w_last_nxt  = w_winner;
        end else if (r_state == ST_OWNED) begin
            if (w_owner_req) begin
                // Saturating hold count: at the limit with nobody waiting, restart.
                if (r_hold == HOLD_LAST) begin
                    w_hold_nxt = '0;
                end else begin
                    w_hold_nxt = r_hold + HOLD_ONE;
                end
            end else begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 3'b000;
                w_valid_nxt = 1'b0;
                w_hold_nxt  = '0;
            end
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CC_MUX3_ARBITER_CLOCK_50) begin
        if (!CC_MUX3_ARBITER_RESET_InLow) begin
            r_state <= ST_IDLE;
            r_grant <= 3'b000;
            r_sel   <= SEL_REQ0;
            r_valid <= 1'b0;
            r_hold  <= '0;
            r_last  <= SEL_REQ2;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_hold  <= w_hold_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign CC_MUX3_ARBITER_Grant_Out    = r_grant;
    assign CC_MUX3_ARBITER_Selector_Out = r_sel;
    assign CC_MUX3_ARBITER_Valid_Out    = r_valid;

endmodule

// File: tb/tb_cc_mux3_arbiter.sv
// Scoreboard bench for cc_mux3_arbiter (MAX_HOLD=4): directed vectors push
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_cc_mux3_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req_in = 3'b000;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       valid;

    typedef struct {
        int unsigned due;
        logic [2:0]  g;
        logic [1:0]  s;
        logic        v;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    cc_mux3_arbiter #(.MAX_HOLD(4), .DATAWIDTH_BUS(8)) dut (
        .CC_MUX3_ARBITER_CLOCK_50     (clk),
        .CC_MUX3_ARBITER_RESET_InLow  (rst_n),
        .CC_MUX3_ARBITER_Request_In   (req_in),
        .CC_MUX3_ARBITER_Grant_Out    (grant),
        .CC_MUX3_ARBITER_Selector_Out (sel),
        .CC_MUX3_ARBITER_Valid_Out    (valid)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that has come due by this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            total = total + 1;
            if (mon_e.due != cyc || grant !== mon_e.g || sel !== mon_e.s || valid !== mon_e.v) begin
                bad = bad + 1;
                $display("FAIL %s cyc=%0d: got grant=%b sel=%b valid=%b, want grant=%b sel=%b valid=%b",
                         mon_e.tag, cyc, grant, sel, valid, mon_e.g, mon_e.s, mon_e.v);
            end
        end
    end

    // Drive one cycle of inputs; the result is visible after the next edge.
    task automatic step(input logic rst, input logic [2:0] req,
                        input logic [2:0] eg, input logic [1:0] es, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n  = rst;
        req_in = req;
        e.due = cyc + 1;
        e.g   = eg;
        e.s   = es;
        e.v   = (eg != 3'b000);
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic rep(input int n, input logic rst, input logic [2:0] req,
                       input logic [2:0] eg, input logic [1:0] es, input string tag);
        for (int i = 0; i < n; i++) step(rst, req, eg, es, tag);
    endtask

    initial begin
        // Reset with requests present: they must be ignored.
        rep(2, 1'b0, 3'b111, 3'b000, 2'b00, "reset");
        step(1'b1, 3'b111, 3'b001, 2'b00, "first_grant");
        // Full contention: each owner keeps the bus exactly 4 cycles.
        rep(3, 1'b1, 3'b111, 3'b001, 2'b00, "rr_hold0");
        rep(4, 1'b1, 3'b111, 3'b010, 2'b01, "rr_hold1");
        rep(4, 1'b1, 3'b111, 3'b100, 2'b10, "rr_hold2");
        step(1'b1, 3'b111, 3'b001, 2'b00, "rr_wrap0");
        // Early release hands over with no bubble.
        step(1'b1, 3'b011, 3'b001, 2'b00, "early_pre");
        step(1'b1, 3'b010, 3'b010, 2'b01, "early_rel");
        step(1'b1, 3'b000, 3'b000, 2'b01, "idle_drop");
        step(1'b1, 3'b000, 3'b000, 2'b01, "idle_hold");
        // Sole requester keeps the grant across hold-counter limits.
        rep(40, 1'b1, 3'b100, 3'b100, 2'b10, "sole_req2");
        step(1'b1, 3'b000, 3'b000, 2'b10, "rel_idle");
        // Pointer-based resolution, not fixed priority.
        step(1'b1, 3'b011, 3'b001, 2'b00, "rr_from2");
        step(1'b1, 3'b000, 3'b000, 2'b00, "idle_again");
        step(1'b1, 3'b101, 3'b100, 2'b10, "rr_skip_prio");
        rep(3, 1'b1, 3'b101, 3'b100, 2'b10, "hold_owner2");
        step(1'b1, 3'b101, 3'b001, 2'b00, "force_sw");
        // Reset in the middle of a grant.
        step(1'b1, 3'b111, 3'b001, 2'b00, "pre_rst");
        step(1'b0, 3'b111, 3'b000, 2'b00, "mid_rst");
        step(1'b1, 3'b111, 3'b001, 2'b00, "post_rst");
        step(1'b1, 3'b000, 3'b000, 2'b00, "final_idle");

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
